// File: rtl/half_adder.sv
// half_adder: unsigned WIDTH-bit add with no carry-in.
// {c_out,s} is the exact sum, delayed LATENCY cycles alongside in_valid.
module half_adder #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             out_valid
);

  localparam int SW = WIDTH + 2;

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};

  generate
    if (LATENCY == 0) begin : g_comb
      // clock and reset have no role in the combinational build
      logic w_unused_clkrst;
      assign w_unused_clkrst = clk ^ rst;

      assign s         = w_sum[WIDTH-1:0];
      assign c_out     = w_sum[WIDTH];
      assign out_valid = in_valid;
    end else begin : g_pipe
      // each stage holds {valid, carry, sum}
      logic [LATENCY-1:0][SW-1:0] r_stage;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stage <= '0;
        end else begin
          r_stage[0] <= {in_valid, w_sum};
          for (int i = 1; i < LATENCY; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign {out_valid, c_out, s} = r_stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder across four configurations.
// Expected {c_out,s} is the integer sum a+b; monitors pop on out_valid.
module tb_half_adder;

  typedef struct {
    int v;
    int t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               n, act, req, cyc);
    end
  endtask

  // W1 L1
  logic rst1 = 1'b1, a1 = 0, b1 = 0, v1 = 0;
  logic s1, c1, ov1;
  exp_t q1[$];
  half_adder #(.WIDTH(1), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(v1),
    .s(s1), .c_out(c1), .out_valid(ov1));

  // W8 L1
  logic rst8 = 1'b1, v8 = 0;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic c8, ov8;
  exp_t q8[$];
  half_adder #(.WIDTH(8), .LATENCY(1)) u8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8), .in_valid(v8),
    .s(s8), .c_out(c8), .out_valid(ov8));

  // W4 L3
  logic rst4 = 1'b1, v4 = 0;
  logic [3:0] a4 = 0, b4 = 0, s4;
  logic c4, ov4;
  exp_t q4[$];
  half_adder #(.WIDTH(4), .LATENCY(3)) u4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .in_valid(v4),
    .s(s4), .c_out(c4), .out_valid(ov4));

  // W1 L0
  logic rst0 = 1'b1, a0 = 0, b0 = 0, v0 = 0;
  logic s0, c0, ov0;
  half_adder #(.WIDTH(1), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst0), .a(a0), .b(b0), .in_valid(v0),
    .s(s0), .c_out(c0), .out_valid(ov0));

  task automatic put1(input logic a, input logic b, input logic v);
    a1 = a; b1 = b; v1 = v;
    if (v && !rst1) q1.push_back('{int'(a) + int'(b), cyc});
  endtask

  task automatic put8(input logic [7:0] a, input logic [7:0] b,
                      input logic v);
    a8 = a; b8 = b; v8 = v;
    if (v && !rst8) q8.push_back('{int'(a) + int'(b), cyc});
  endtask

  task automatic put4(input logic [3:0] a, input logic [3:0] b,
                      input logic v);
    a4 = a; b4 = b; v4 = v;
    if (v && !rst4) q4.push_back('{int'(a) + int'(b), cyc});
  endtask

  // monitors: out_valid must rise exactly when the head entry is due
  exp_t e1, e8, e4;
  logic ev1, ev8, ev4;

  always begin
    @(posedge clk);
    #1;
    ev1 = (q1.size() > 0) && (q1[0].t + 1 == cyc);
    chk("ov_w1", 32'(ov1), 32'(ev1));
    if (ev1) begin
      e1 = q1.pop_front();
      chk("sum_w1", 32'({c1, s1}), e1.v);
    end
  end

  always begin
    @(posedge clk);
    #1;
    ev8 = (q8.size() > 0) && (q8[0].t + 1 == cyc);
    chk("ov_w8", 32'(ov8), 32'(ev8));
    if (ev8) begin
      e8 = q8.pop_front();
      chk("sum_w8", 32'({c8, s8}), e8.v);
    end
  end

  always begin
    @(posedge clk);
    #1;
    ev4 = (q4.size() > 0) && (q4[0].t + 3 == cyc);
    chk("ov_w4l3", 32'(ov4), 32'(ev4));
    if (ev4) begin
      e4 = q4.pop_front();
      chk("sum_w4l3", 32'({c4, s4}), e4.v);
    end
  end

  initial begin
    logic [3:0] ab;
    logic [7:0] ra, rb;
    int k;

    // reset state, rst held from time 0
    #2;
    chk("rst_w1", 32'({ov1, c1, s1}), 0);
    chk("rst_w8", 32'({ov8, c8, s8}), 0);
    chk("rst_w4", 32'({ov4, c4, s4}), 0);
    @(negedge clk);
    @(negedge clk);
    rst1 = 0; rst8 = 0; rst4 = 0;

    // exhaustive 1-bit truth table
    for (int i = 0; i < 4; i++) begin
      ab = 4'(i);
      put1(ab[1], ab[0], 1'b1);
      @(negedge clk);
    end
    put1(0, 0, 0);
    @(negedge clk);

    // asynchronous reset with a=b=1 held
    put1(1, 1, 1'b1);
    @(negedge clk);
    rst1 = 1;
    q1.delete();
    #1;
    chk("async_rst_w1", 32'({ov1, c1, s1}), 0);
    @(negedge clk);
    @(negedge clk);
    rst1 = 0;
    put1(1, 1, 1'b1);
    @(negedge clk);
    put1(0, 0, 0);

    // wide carry boundaries
    put8(8'hFF, 8'h01, 1);
    @(negedge clk);
    put8(8'h7F, 8'h01, 1);
    @(negedge clk);
    put8(8'hFF, 8'hFF, 1);
    @(negedge clk);
    put8(0, 0, 0);

    // deep pipeline stream a=i, b=15-i, then a bubble
    for (int i = 0; i < 16; i++) begin
      put4(4'(i), 4'(15 - i), 1);
      @(negedge clk);
    end
    put4(0, 0, 0);
    repeat (5) @(negedge clk);

    // reset in mid-stream discards in-flight results
    for (int i = 0; i < 20; i++) begin
      if (i == 7) begin
        rst4 = 1;
        q4.delete();
        #1;
        chk("mid_rst_w4", 32'({ov4, c4, s4}), 0);
      end else if (i == 8) begin
        rst4 = 0;
      end
      put4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0));
      @(negedge clk);
    end
    put4(0, 0, 0);

    // randomized traffic on all clocked builds
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      put1(ra[0], rb[0], 1'($urandom));
      put8(ra, rb, 1'($urandom_range(0, 4) != 0));
      put4(ra[7:4], rb[7:4], 1'($urandom));
      @(negedge clk);
    end
    put1(0, 0, 0);
    put8(0, 0, 0);
    put4(0, 0, 0);
    repeat (6) @(negedge clk);

    chk("drain_w1", q1.size(), 0);
    chk("drain_w8", q8.size(), 0);
    chk("drain_w4", q4.size(), 0);

    // combinational build, rst held high to show it has no effect
    for (int i = 0; i < 8; i++) begin
      ab = 4'(i);
      a0 = ab[1];
      b0 = ab[0];
      v0 = ab[2];
      #10;
      k = int'(ab[1]) + int'(ab[0]);
      chk("comb_sum", 32'({c0, s0}), k);
      chk("comb_ov", 32'(ov0), 32'(ab[2]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/half_adder.md
# half_adder

Pipelined, parameterizable half adder. Adds two unsigned operands with no carry-in, producing a sum and a carry-out after a fixed, configurable latency. It is the basic arithmetic leaf cell used to build full adders and wider adder chains. With the default configuration (1-bit operands, one register stage) it provides the classic 1-bit half adder truth table, registered.

## Interface
Clocking is decided: one clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, default 1: operand and sum width in bits; legal range is at least 1.
- LATENCY, default 1: number of register stages from inputs to outputs; legal range is at least 0. A value of 0 gives a purely combinational path.

Ports:
- clk, input, 1 bit: clock, rising-edge active.
- rst, input, 1 bit: asynchronous, active-high reset that clears every pipeline stage.
- a, input, WIDTH bits: operand A, unsigned.
- b, input, WIDTH bits: operand B, unsigned.
- in_valid, input, 1 bit: marks a/b as a meaningful sample. It is carried alongside the data only and does not gate the datapath.
- s, output, WIDTH bits: sum, equal to (a + b) mod 2^WIDTH.
- c_out, output, 1 bit: carry-out, bit WIDTH of a + b.
- out_valid, output, 1 bit: in_valid delayed by exactly LATENCY cycles.

## Operation
- Arithmetic: compute a (WIDTH+1)-bit result r = {1'b0,a} + {1'b0,b}. Then s = r[WIDTH-1:0] and c_out = r[WIDTH].
- For WIDTH=1 this reduces to s = a XOR b and c_out = a AND b. The full truth table is 00 -> 00, 01 -> 01, 10 -> 01, 11 -> 10, written as ab -> {c_out,s}.
- The combination {c_out,s} always equals the exact arithmetic sum a + b. No overflow is possible.
- Datapath stages capture on every rising clk edge, whatever in_valid is. in_valid travels through a parallel 1-bit shift chain of the same depth.
- The addition is performed before the first register stage. The remaining LATENCY-1 stages only delay {out_valid, c_out, s}.
- When LATENCY=0:
  - s and c_out are combinational functions of a and b.
  - out_valid = in_valid.
  - clk and rst are unused, but the ports are still present.
- There is no stall or backpressure. The block accepts a new operand pair every cycle.

## Timing
- Latency: the a/b/in_valid sampled at clock edge N appear on s/c_out/out_valid right after edge N+LATENCY-1, counting edge N as the first.
- Throughput: one result per cycle. The outputs of consecutive samples never merge or skip.
- Reset values: while rst=1, s=0, c_out=0 and out_valid=0. Every internal stage is cleared.
- rst acts immediately, without waiting for a clock edge. Its assertion clears the outputs within the same cycle.
- Reset in mid-operation: samples already in flight are discarded.
- After rst deasserts, out_valid stays 0 until the first post-reset sample with in_valid=1 has travelled through all LATENCY stages.
- If rst is asserted on the same edge as a capture, reset wins.
- LATENCY=0: outputs settle combinationally within the same cycle. rst has no effect.
- X-propagation: inputs that are X or Z may produce an X output. The bench drives known values only.

## Test plan
- Exhaustive 1-bit check (WIDTH=1, LATENCY=1). Drive ab = 00, 01, 10, 11 in consecutive cycles with in_valid=1. Required: one cycle later, {c_out,s} = 00, 01, 01, 10 and out_valid=1 each cycle.
- Reset (WIDTH=1, LATENCY=1). Hold a=1, b=1 and assert rst for 2 cycles between clock edges. Required: s=0, c_out=0 and out_valid=0 immediately, with no clock edge needed. After deassertion, {c_out,s}=10 follows one edge later.
- Wide carry (WIDTH=8, LATENCY=1). Drive a=0xFF, b=0x01. Required: s=0x00, c_out=1. Then drive a=0x7F, b=0x01. Required: s=0x80, c_out=0.
- Deep pipeline (WIDTH=4, LATENCY=3). Stream a=i, b=15-i for i=0..15 with in_valid=1, then one cycle with in_valid=0. Required: every result is s=0xF, c_out=0, appearing 3 cycles after its input. out_valid then drops 3 cycles after in_valid falls.
- Reset in mid-stream (WIDTH=4, LATENCY=3). Assert rst for 1 cycle during streaming. Required: the in-flight results are lost, out_valid is 0 until 3 cycles after the first post-reset valid input, and the next results are exact.
- Combinational mode (WIDTH=1, LATENCY=0). Apply all four ab combinations with 10 ns spacing and no clock. Required: the truth table above holds at each step and out_valid equals in_valid.
